alu_bitserial: RTL

//   Bit-serial ALU: executes one WIDTH-bit ALU operation over WIDTH clocks, one bit per clock, LSB first.
//   Per-bit datapath is the standard slice: a/b inversion, AND, OR, full-add, 4:1 result select.

---
 rtl/alu_bitserial.sv | 123 ++++++++++++
 1 files changed

// File: rtl/alu_bitserial.sv
// Bit-serial ALU: one WIDTH-bit AND/OR/ADD/SUB/SLT/NOR operation over WIDTH clocks,
// LSB first, behind a valid/ready handshake on both sides.
module alu_bitserial #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [3:0]       op_q;
  logic [CW-1:0]    count;
  logic             carry;

  logic             a_bit;
  logic             b_bit;
  logic             sum_bit;
  logic             carry_nx;
  logic             bit_res;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] final_res;

  // One ALU slice operating on the current LSB of the operand shift registers
  always_comb begin
    a_bit    = a_sh[0] ^ op_q[3];
    b_bit    = b_sh[0] ^ op_q[2];
    sum_bit  = a_bit ^ b_bit ^ carry;
    carry_nx = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
    bit_res  = 1'b0;
    case (op_q[1:0])
      2'b00:   bit_res = a_bit & b_bit;
      2'b01:   bit_res = a_bit | b_bit;
      2'b10:   bit_res = sum_bit;
      default: bit_res = 1'b0;
    endcase
    res_next = {bit_res, res_sh[WIDTH-1:1]};
    // SLT: on the last bit sum_bit is the MSB sum, which becomes result bit 0
    final_res = (op_q[1:0] == 2'b11) ? {{(WIDTH-1){1'b0}}, sum_bit} : res_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      op_q      <= '0;
      count     <= '0;
      carry     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= b;
            op_q     <= op;
            count    <= '0;
            carry    <= op[2];
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          carry  <= carry_nx;
          if (count == CW'(WIDTH - 1)) begin
            cout      <= carry_nx;
            overflow  <= carry ^ carry_nx;
            result    <= final_res;
            zero      <= ~|final_res;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
